muldiv_issue_controller: RTL

Issue and writeback controller for the shared multi-cycle multiply/divide unit of the RV64 integer pipeline. Sits beside the ID-stage hazard logic. It accepts mul/div ops leaving ID, sequences the unit through a latency countdown, and holds a one-entry scoreboard for the pending destination register. It stalls dependent or structurally conflicting instructions in ID and arbitrates the unit's result onto the shared writeback port.

---
 rtl/muldiv_issue_controller_pkg.sv | 14 +
 rtl/muldiv_issue_controller_md_scoreboard.sv | 48 ++++
 rtl/muldiv_issue_controller.sv | 107 ++++++++++
 3 files changed

// File: rtl/muldiv_issue_controller_pkg.sv
// Shared types and constants for the mul/div issue controller and its scoreboard.
package muldiv_issue_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_WB   = 2'd2
  } md_state_e;

  localparam int CNT_W       = 6;
  localparam int DEF_MUL_LAT = 3;
  localparam int DEF_DIV_LAT = 33;

endpackage

// File: rtl/muldiv_issue_controller_md_scoreboard.sv
// One-entry pending-destination scoreboard with RAW/WAW hazard compare.
module muldiv_issue_controller_md_scoreboard (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic [4:0] set_rd,
  input  logic       clr_en,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       uses_rs,
  input  logic       uses_rt,
  input  logic [4:0] rd_id,
  input  logic       writes_rd,
  output logic       pend_valid,
  output logic [4:0] pend_rd,
  output logic       hazard
);

  logic       pend_valid_r;
  logic [4:0] pend_rd_r;
  logic       raw_s;
  logic       waw_s;

  // Pending entry: x0 destinations are never marked valid, so x0 sources never match.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid_r <= 1'b0;
      pend_rd_r    <= 5'd0;
    end else if (set_en) begin
      pend_valid_r <= (set_rd != 5'd0);
      pend_rd_r    <= set_rd;
    end else if (clr_en) begin
      pend_valid_r <= 1'b0;
    end
  end

  // Hazard compare against the pending destination.
  always_comb begin
    raw_s  = pend_valid_r & ((uses_rs & (rs_id == pend_rd_r)) |
                             (uses_rt & (rt_id == pend_rd_r)));
    waw_s  = pend_valid_r & writes_rd & (rd_id == pend_rd_r);
    hazard = raw_s | waw_s;
  end

  assign pend_valid = pend_valid_r;
  assign pend_rd    = pend_rd_r;

endmodule

// File: rtl/muldiv_issue_controller.sv
// Issue/writeback sequencer for the shared multi-cycle mul/div unit; stalls ID on hazards.
module muldiv_issue_controller
  import muldiv_issue_controller_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_valid,
  input  logic       issue_is_md,
  input  logic       issue_is_div,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       uses_rs,
  input  logic       uses_rt,
  input  logic [4:0] rd_id,
  input  logic       writes_rd,
  input  logic       flush,
  input  logic       wb_slot_free,
  output logic       md_start,
  output logic       md_is_div,
  output logic       md_busy,
  output logic       stall_id,
  output logic       md_wb_valid,
  output logic [4:0] md_wb_rd
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 2);

  md_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             pend_valid_s;
  logic [4:0]       pend_rd_s;
  logic             hazard_s;
  logic             issue_fire_s;
  logic             wb_done_s;

  // Stall, issue and writeback-completion decode; a flushed instruction never stalls or issues.
  always_comb begin
    if (issue_valid && !flush) begin
      stall_id = hazard_s | (issue_is_md & (state_r != ST_IDLE));
    end else begin
      stall_id = 1'b0;
    end
    issue_fire_s = issue_valid & issue_is_md & ~flush & ~stall_id & (state_r == ST_IDLE);
    wb_done_s    = (state_r == ST_WB) & (wb_slot_free | ~pend_valid_s);
  end

  // Controller FSM with latency countdown.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (issue_fire_s) begin
            state_r <= ST_BUSY;
            cnt_r   <= issue_is_div ? DIV_CNT : MUL_CNT;
          end
        end
        ST_BUSY: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= ST_WB;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_WB: begin
          if (wb_done_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  muldiv_issue_controller_md_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (issue_fire_s),
    .set_rd     (rd_id),
    .clr_en     (wb_done_s),
    .rs_id      (rs_id),
    .rt_id      (rt_id),
    .uses_rs    (uses_rs),
    .uses_rt    (uses_rt),
    .rd_id      (rd_id),
    .writes_rd  (writes_rd),
    .pend_valid (pend_valid_s),
    .pend_rd    (pend_rd_s),
    .hazard     (hazard_s)
  );

  assign md_start    = issue_fire_s;
  assign md_is_div   = issue_fire_s & issue_is_div;
  assign md_busy     = (state_r != ST_IDLE);
  assign md_wb_valid = (state_r == ST_WB) & pend_valid_s;
  assign md_wb_rd    = md_wb_valid ? pend_rd_s : 5'd0;

endmodule
